// File: rtl/pulse_width_gen.sv
// One-shot pulse generator: a one-cycle trig produces a registered pulse of exactly `width` cycles,
// followed by `holdoff` dead cycles. Define PULSE_COUNT_EN to add the 16-bit pulse_cnt output.
module pulse_width_gen #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          DROP_ON_BUSY = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] holdoff,
  output logic             pulse_out,
  output logic             busy,
  output logic             trig_drop
`ifdef PULSE_COUNT_EN
  ,
  output logic [15:0]      pulse_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             pend_q, pend_d;
  logic             start;
  logic             finish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          if (width != '0) start = 1'b1;
          else             drop_d = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pulse_d = 1'b0;
          if (hold_q != '0) begin
            cnt_d   = hold_q - CNT_W'(1);
            state_d = HOLD;
          end else begin
            finish = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && trig) begin
      if (DROP_ON_BUSY || pend_q) drop_d = 1'b1;
      else                        pend_d = 1'b1;
    end

    // A queued trig (including one landing in the final busy cycle) restarts
    // directly from the last busy cycle, so busy never dips between pulses.
    if (finish) begin
      if (pend_d) begin
        pend_d = 1'b0;
        if (width != '0) begin
          start = 1'b1;
        end else begin
          drop_d  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end

    if (start) begin
      state_d = HIGH;
      cnt_d   = width - CNT_W'(1);
      hold_d  = holdoff;
      pulse_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PULSE_COUNT_EN
  logic [15:0] pcnt_q;

  // Counts every pulse actually started, including serviced queued trigs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pcnt_q <= '0;
    else if (start) pcnt_q <= pcnt_q + 16'd1;
  end

  assign pulse_cnt = pcnt_q;
`endif

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign trig_drop = drop_q;

endmodule

// File: tb/tb_pulse_width_gen.sv
// Scoreboard bench: two instances (drop-on-busy and queue-one) share stimulus; expected
// edge events are queued per instance and a negedge monitor pops and compares observed edges.
module tb_pulse_width_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trig;
  logic [15:0] width;
  logic [15:0] holdoff;
  logic        po0, bz0, dr0;
  logic        po1, bz1, dr1;
`ifdef PULSE_COUNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_width_gen #(.CNT_W(16), .DROP_ON_BUSY(1'b1)) u_drop (
    .clk(clk), .reset_n(reset_n), .trig(trig), .width(width), .holdoff(holdoff),
    .pulse_out(po0), .busy(bz0), .trig_drop(dr0)
`ifdef PULSE_COUNT_EN
    , .pulse_cnt(cnt0)
`endif
  );

  pulse_width_gen #(.CNT_W(16), .DROP_ON_BUSY(1'b0)) u_queue (
    .clk(clk), .reset_n(reset_n), .trig(trig), .width(width), .holdoff(holdoff),
    .pulse_out(po1), .busy(bz1), .trig_drop(dr1)
`ifdef PULSE_COUNT_EN
    , .pulse_cnt(cnt1)
`endif
  );

  // Event kinds: 0 pulse rise, 1 pulse fall, 2 busy rise, 3 busy fall, 4 trig_drop.
  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  function automatic string kname(input int k);
    case (k)
      0: return "pulse_rise";
      1: return "pulse_fall";
      2: return "busy_rise";
      3: return "busy_fall";
      default: return "trig_drop";
    endcase
  endfunction

  task automatic expect_ev(input int d, input int k, input int c);
    ev_t e;
    e.kind = 3'(k);
    e.cyc  = 32'(c);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic expect_both(input int k, input int c);
    expect_ev(0, k, c);
    expect_ev(1, k, c);
  endtask

  task automatic check_ev(input int d, input int k);
    ev_t e;
    vectors++;
    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d event: got %s@%0d, expected none", d, kname(k), cyc);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (int'(e.kind) != k || e.cyc != 32'(cyc)) begin
        miscompares++;
        $display("FAIL dut%0d event: got %s@%0d, expected %s@%0d",
                 d, kname(k), cyc, kname(int'(e.kind)), e.cyc);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  logic pp0 = 1'b0, pb0 = 1'b0, pp1 = 1'b0, pb1 = 1'b0;

  always @(negedge clk) begin
    logic [4:0] ev0, ev1;
    ev0 = {dr0, !bz0 && pb0, bz0 && !pb0, !po0 && pp0, po0 && !pp0};
    ev1 = {dr1, !bz1 && pb1, bz1 && !pb1, !po1 && pp1, po1 && !pp1};
    for (int k = 0; k < 5; k++) begin
      if (ev0[k]) check_ev(0, k);
      if (ev1[k]) check_ev(1, k);
    end
    pp0 = po0; pb0 = bz0; pp1 = po1; pb1 = bz1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic fire(input logic [15:0] w, input logic [15:0] h);
    width   = w;
    holdoff = h;
    trig    = 1'b1;
    step(1);
    trig    = 1'b0;
  endtask

  int t;

  initial begin
    reset_n = 1'b0;
    trig    = 1'b0;
    width   = '0;
    holdoff = '0;
    step(3);
    check_val("reset pulse_out dut0", int'(po0), 0);
    check_val("reset busy dut0", int'(bz0), 0);
    check_val("reset trig_drop dut0", int'(dr0), 0);
    check_val("reset pulse_out dut1", int'(po1), 0);
    check_val("reset busy dut1", int'(bz1), 0);
    check_val("reset trig_drop dut1", int'(dr1), 0);
    reset_n = 1'b1;
    step(2);

    // width 5, holdoff 3; inputs changed mid-pulse must not matter
    t = cyc + 1;
    expect_both(0, t + 1); expect_both(2, t + 1);
    expect_both(1, t + 6); expect_both(3, t + 9);
    go_to(t); fire(16'd5, 16'd3);
    width = 16'd2; holdoff = 16'd7;
    go_to(t + 14);

    // two 1-cycle pulses, trigs 2 apart
    t = cyc + 1;
    expect_both(0, t + 1); expect_both(2, t + 1); expect_both(1, t + 2); expect_both(3, t + 2);
    expect_both(0, t + 3); expect_both(2, t + 3); expect_both(1, t + 4); expect_both(3, t + 4);
    go_to(t); fire(16'd1, 16'd0);
    go_to(t + 2); fire(16'd1, 16'd0);
    go_to(t + 8);

    // width 8, holdoff 2, second trig 3 cycles into pulse
    t = cyc + 1;
    expect_ev(0, 0, t + 1); expect_ev(0, 2, t + 1); expect_ev(0, 4, t + 5);
    expect_ev(0, 1, t + 9); expect_ev(0, 3, t + 11);
    expect_ev(1, 0, t + 1); expect_ev(1, 2, t + 1); expect_ev(1, 1, t + 9);
    expect_ev(1, 0, t + 11); expect_ev(1, 1, t + 19); expect_ev(1, 3, t + 21);
    go_to(t); fire(16'd8, 16'd2);
    go_to(t + 4); fire(16'd8, 16'd2);
    go_to(t + 25);

    // width 4, holdoff 2: trig in HIGH, another in HOLD
    t = cyc + 1;
    expect_ev(0, 0, t + 1); expect_ev(0, 2, t + 1); expect_ev(0, 4, t + 3);
    expect_ev(0, 1, t + 5); expect_ev(0, 4, t + 6); expect_ev(0, 3, t + 7);
    expect_ev(1, 0, t + 1); expect_ev(1, 2, t + 1); expect_ev(1, 1, t + 5);
    expect_ev(1, 4, t + 6); expect_ev(1, 0, t + 7); expect_ev(1, 1, t + 11);
    expect_ev(1, 3, t + 13);
    go_to(t); fire(16'd4, 16'd2);
    go_to(t + 2); fire(16'd4, 16'd2);
    go_to(t + 5); fire(16'd4, 16'd2);
    go_to(t + 18);

    // trig in the final hold-off cycle
    t = cyc + 1;
    expect_ev(0, 0, t + 1); expect_ev(0, 2, t + 1); expect_ev(0, 1, t + 3);
    expect_ev(0, 3, t + 5); expect_ev(0, 4, t + 5);
    expect_ev(1, 0, t + 1); expect_ev(1, 2, t + 1); expect_ev(1, 1, t + 3);
    expect_ev(1, 0, t + 5); expect_ev(1, 1, t + 7); expect_ev(1, 3, t + 9);
    go_to(t); fire(16'd2, 16'd2);
    go_to(t + 4); fire(16'd2, 16'd2);
    go_to(t + 14);

    // width 0: flagged, no pulse
    t = cyc + 1;
    expect_both(4, t + 1);
    go_to(t); fire(16'd0, 16'd5);
    go_to(t + 5);

`ifdef PULSE_COUNT_EN
    check_val("pulse_cnt dut0", int'(cnt0), 6);
    check_val("pulse_cnt dut1", int'(cnt1), 9);
`endif

    // reset mid-pulse, then a clean 3-cycle pulse
    t = cyc + 1;
    expect_both(0, t + 1); expect_both(2, t + 1);
    expect_both(1, t + 41); expect_both(3, t + 41);
    go_to(t); fire(16'd100, 16'd0);
    go_to(t + 41);
    #2 reset_n = 1'b0;
    #1;
    check_val("async reset pulse_out dut0", int'(po0), 0);
    check_val("async reset busy dut0", int'(bz0), 0);
    check_val("async reset pulse_out dut1", int'(po1), 0);
    check_val("async reset busy dut1", int'(bz1), 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    t = cyc + 1;
    expect_both(0, t + 1); expect_both(2, t + 1);
    expect_both(1, t + 4); expect_both(3, t + 4);
    go_to(t); fire(16'd3, 16'd0);
    go_to(t + 8);

`ifdef PULSE_COUNT_EN
    check_val("pulse_cnt after reset dut0", int'(cnt0), 1);
    check_val("pulse_cnt after reset dut1", int'(cnt1), 1);
`endif

    while (q0.size() != 0) begin
      ev_t e;
      e = q0.pop_front();
      vectors++; miscompares++;
      $display("FAIL dut0 event: got none, expected %s@%0d", kname(int'(e.kind)), e.cyc);
    end
    while (q1.size() != 0) begin
      ev_t e;
      e = q1.pop_front();
      vectors++; miscompares++;
      $display("FAIL dut1 event: got none, expected %s@%0d", kname(int'(e.kind)), e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
